// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, 3-sample majority voting,
// parity/framing/break detection, and a show-ahead receive FIFO.
module uart_rx_cfg #(
  parameter int FREQUENCY  = 10_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             rx_serial,
  output logic [DATA_BITS-1:0]             rx_data,
  output logic                             rx_parity_err,
  output logic                             rx_frame_err,
  output logic                             rx_break,
  output logic                             rx_valid,
  input  logic                             rx_ready,
  output logic                             rx_overflow,
  input  logic                             clear_overflow,
  output logic                             rx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int CLKS_PER_BIT = FREQUENCY / BAUD_RATE;
  localparam int MID = (CLKS_PER_BIT - 1) / 2;
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int EW  = DATA_BITS + 3;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int NW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] SAMP0    = CW'(MID - 1);
  localparam logic [CW-1:0] SAMP1    = CW'(MID);
  localparam logic [CW-1:0] SAMP2    = CW'(MID + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP, ST_HOLD} state_t;

  logic                 sync1_q, sync2_q;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d;

  logic s, maj, at_end, push;
  logic ferr_now, perr_now, brk_now;
  logic full, do_push, do_pop, ovf_evt;
  logic [EW-1:0] entry, head;

  assign s      = sync2_q;
  assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & s) | (samp_q[1] & s);
  assign at_end = (cnt_q == CNT_LAST);

  // Status of the character as it stands at the final stop-bit sample.
  assign ferr_now = ferr_q | ~maj;
  assign perr_now = (PARITY == 0) ? 1'b0 :
                    (PARITY == 2) ? (^{data_q, par_q}) : ~(^{data_q, par_q});
  assign brk_now  = ferr_now && (data_q == '0) && ((PARITY == 0) || !par_q);
  assign entry    = {brk_now, ferr_now, perr_now, data_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = at_end ? '0 : cnt_q + CW'(1);
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    samp_d     = samp_q;
    data_d     = data_q;
    par_d      = par_q;
    ferr_d     = ferr_q;
    push       = 1'b0;
    if (cnt_q == SAMP0) samp_d[0] = s;
    if (cnt_q == SAMP1) samp_d[1] = s;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!s) state_d = ST_START;
      end
      ST_START: begin
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
        ferr_d     = 1'b0;
        if (cnt_q == SAMP2 && maj) state_d = ST_IDLE;
        else if (at_end)           state_d = ST_DATA;
      end
      ST_DATA: begin
        if (cnt_q == SAMP2) data_d = {maj, data_q[DATA_BITS-1:1]};
        if (at_end) begin
          if (bit_idx_q == BIT_LAST) state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
          else                       bit_idx_d = bit_idx_q + BW'(1);
        end
      end
      ST_PAR: begin
        if (cnt_q == SAMP2) par_d = maj;
        if (at_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (cnt_q == SAMP2) begin
          ferr_d = ferr_now;
          // Commit mid-bit so the next start edge can be caught promptly.
          if (stop_idx_q == STOP_LAST) begin
            push    = 1'b1;
            state_d = s ? ST_IDLE : ST_HOLD;
          end
        end
        if (at_end) stop_idx_d = 1'b1;
      end
      ST_HOLD: begin
        cnt_d = '0;
        if (s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign full    = (count_q == DEPTH_N);
  assign rx_valid = (count_q != '0);
  assign do_pop  = rx_valid && rx_ready;
  assign do_push = push && (!full || do_pop);
  assign ovf_evt = push && full && !do_pop;
  assign count_d = count_q + NW'(do_push) - NW'(do_pop);
  assign ovf_d   = (ovf_q && !clear_overflow) || ovf_evt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      samp_q     <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      ferr_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      sync1_q    <= rx_serial;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      samp_q     <= samp_d;
      data_q     <= data_d;
      par_q      <= par_d;
      ferr_q     <= ferr_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry;
  end

  assign head          = mem_q[rd_ptr_q];
  assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
  assign rx_parity_err = rx_valid & head[EW-3];
  assign rx_frame_err  = rx_valid & head[EW-2];
  assign rx_break      = rx_valid & head[EW-1];
  assign rx_overflow   = ovf_q;
  assign rx_busy       = (state_q != ST_IDLE);
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 instance (A) and a 7E2 instance (B)
// driven at 16 clocks per bit, checked against hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       line_a = 1'b1, line_b = 1'b1;
  logic       ready_a = 1'b0, ready_b = 1'b0, clr_a = 1'b0, clr_b = 1'b0;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       perr_a, ferr_a, brk_a, valid_a, ovf_a, busy_a;
  logic       perr_b, ferr_b, brk_b, valid_b, ovf_b, busy_b;
  logic [2:0] cnt_a, cnt_b;

  uart_rx_cfg #(.FREQUENCY(16_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .rx_serial(line_a), .rx_data(data_a),
    .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .rx_break(brk_a),
    .rx_valid(valid_a), .rx_ready(ready_a), .rx_overflow(ovf_a),
    .clear_overflow(clr_a), .rx_busy(busy_a), .fifo_count(cnt_a));

  uart_rx_cfg #(.FREQUENCY(16_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(7),
                .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .rx_serial(line_b), .rx_data(data_b),
    .rx_parity_err(perr_b), .rx_frame_err(ferr_b), .rx_break(brk_b),
    .rx_valid(valid_b), .rx_ready(ready_b), .rx_overflow(ovf_b),
    .clear_overflow(clr_b), .rx_busy(busy_b), .fifo_count(cnt_b));

  typedef struct {
    int         d;
    logic [8:0] data;
    bit         pflip;
    bit         slow;
    logic [8:0] exp_data;
    bit         exp_p;
    bit         exp_f;
    bit         exp_b;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_line(input int d, input logic v);
    if (d == 0) line_a = v;
    else        line_b = v;
  endtask

  function automatic logic valid_of(input int d);
    return (d == 0) ? valid_a : valid_b;
  endfunction

  function automatic int count_of(input int d);
    return (d == 0) ? int'(cnt_a) : int'(cnt_b);
  endfunction

  // Frame bits LSB first: start, data, [parity], stop(s); slow forces last stop low.
  function automatic logic [15:0] frame_bits(input int d, input logic [8:0] data,
                                             input bit pflip, input bit slow);
    logic p;
    p = (^data[6:0]) ^ pflip;
    if (d == 0) return {6'b0, ~slow, data[7:0], 1'b0};
    return {5'b0, ~slow, 1'b1, p, data[6:0], 1'b0};
  endfunction

  task automatic drive_bits(input int d, input logic [15:0] bits, input int n);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      set_line(d, bits[i]);
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_char(input int d, input logic [8:0] data, input bit pflip, input bit slow);
    drive_bits(d, frame_bits(d, data, pflip, slow), (d == 0) ? 10 : 11);
    set_line(d, 1'b1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int d, input string name);
    for (int i = 0; i < 200 && !valid_of(d); i++) begin
      @(posedge clk); #1;
    end
    chk(name, valid_of(d), 1);
  endtask

  task automatic get_head(input int d, output logic [8:0] dt, output logic p,
                          output logic f, output logic b);
    if (d == 0) begin dt = {1'b0, data_a}; p = perr_a; f = ferr_a; b = brk_a; end
    else        begin dt = {2'b0, data_b}; p = perr_b; f = ferr_b; b = brk_b; end
  endtask

  task automatic pop(input int d);
    if (d == 0) ready_a = 1'b1;
    else        ready_b = 1'b1;
    @(posedge clk); #1;
    ready_a = 1'b0;
    ready_b = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [8:0] hd;
    logic       hp, hf, hb;

    vecs[0]  = '{0, 9'h000, 0, 0, 9'h000, 0, 0, 0};
    vecs[1]  = '{0, 9'h0FF, 0, 0, 9'h0FF, 0, 0, 0};
    vecs[2]  = '{0, 9'h03C, 0, 1, 9'h03C, 0, 1, 0};
    vecs[3]  = '{0, 9'h000, 0, 1, 9'h000, 0, 1, 1};
    vecs[4]  = '{1, 9'h035, 0, 0, 9'h035, 0, 0, 0};
    vecs[5]  = '{1, 9'h035, 1, 0, 9'h035, 1, 0, 0};
    vecs[6]  = '{1, 9'h055, 0, 1, 9'h055, 0, 1, 0};
    vecs[7]  = '{1, 9'h000, 0, 1, 9'h000, 0, 1, 1};
    vecs[8]  = '{1, 9'h000, 1, 0, 9'h000, 1, 0, 0};
    vecs[9]  = '{1, 9'h07F, 0, 0, 9'h07F, 0, 0, 0};
    vecs[10] = '{1, 9'h000, 1, 1, 9'h000, 1, 1, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_flags", {perr_a, ferr_a, brk_a}, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_count", cnt_a, 0);
    chk("rst_count_b", cnt_b, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic 8N1 with exact push latency: valid appears right after the stop-bit count-8 sample
    fork
      drive_bits(0, frame_bits(0, 9'h0A5, 0, 0), 10);
      begin
        @(posedge clk); #1;
        repeat (155) @(posedge clk);
        #1;
        chk("lat_before", valid_a, 0);
        @(posedge clk); #1;
        chk("lat_after", valid_a, 1);
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("a5_data", data_a, 8'hA5);
    chk("a5_flags", {perr_a, ferr_a, brk_a}, 0);
    $display("basic: data=%0h flags=%0b%0b%0b", data_a, perr_a, ferr_a, brk_a);
    pop(0);
    chk("a5_empty", valid_a, 0);

    // Table vectors
    for (int i = 0; i < NV; i++) begin
      send_char(vecs[i].d, vecs[i].data, vecs[i].pflip, vecs[i].slow);
      wait_valid(vecs[i].d, $sformatf("v%0d_valid", i));
      get_head(vecs[i].d, hd, hp, hf, hb);
      chk($sformatf("v%0d_data", i), hd, vecs[i].exp_data);
      chk($sformatf("v%0d_perr", i), hp, vecs[i].exp_p);
      chk($sformatf("v%0d_ferr", i), hf, vecs[i].exp_f);
      chk($sformatf("v%0d_brk", i), hb, vecs[i].exp_b);
      $display("vec %0d dut%0d: data=%0h perr=%0b ferr=%0b brk=%0b", i, vecs[i].d, hd, hp, hf, hb);
      pop(vecs[i].d);
      chk($sformatf("v%0d_empty", i), count_of(vecs[i].d), 0);
    end

    // Overflow: five characters into a four-entry FIFO with the consumer stalled
    for (int k = 1; k <= 5; k++) send_char(0, 9'(k), 0, 0);
    chk("ovf_count", cnt_a, 4);
    chk("ovf_flag", ovf_a, 1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf_drain%0d", k), data_a, k);
      $display("drain: data=%0h count=%0d", data_a, cnt_a);
      pop(0);
    end
    chk("ovf_drained", valid_a, 0);
    chk("ovf_sticky", ovf_a, 1);
    clr_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
    chk("ovf_cleared", ovf_a, 0);

    // Glitch: 3-clock low pulse
    @(posedge clk); #1;
    line_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    line_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("glitch_busy", busy_a, 1);
    repeat (30) @(posedge clk);
    #1;
    chk("glitch_idle", busy_a, 0);
    chk("glitch_nopush", cnt_a, 0);
    $display("glitch: busy=%0b count=%0d", busy_a, cnt_a);

    // Break: line low for two character times
    @(posedge clk); #1;
    line_a = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("brk_one_entry", cnt_a, 1);
    chk("brk_hold_busy", busy_a, 1);
    repeat (20) @(posedge clk);
    #1;
    line_a = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("brk_released", busy_a, 0);
    chk("brk_no_second", cnt_a, 1);
    chk("brk_data", data_a, 0);
    chk("brk_ferr", ferr_a, 1);
    chk("brk_flag", brk_a, 1);
    $display("break: data=%0h ferr=%0b brk=%0b", data_a, ferr_a, brk_a);
    pop(0);

    // Full FIFO on B: pop exactly on the push edge of the fifth character
    for (int k = 1; k <= 4; k++) send_char(1, 9'(8'h10 + k), 0, 0);
    chk("pp_full", cnt_b, 4);
    fork
      drive_bits(1, frame_bits(1, 9'h015, 0, 0), 11);
      begin
        @(posedge clk); #1;
        repeat (171) @(posedge clk);
        #1;
        ready_b = 1'b1;
        @(posedge clk); #1;
        ready_b = 1'b0;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("pp_count", cnt_b, 4);
    chk("pp_no_ovf", ovf_b, 0);
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("pp_drain%0d", k), data_b, 8'h10 + k);
      $display("pp drain: data=%0h count=%0d", data_b, cnt_b);
      pop(1);
    end

    // Reset during data bit 3, with a character already queued
    send_char(0, 9'h011, 0, 0);
    chk("mid_pre_count", cnt_a, 1);
    drive_bits(0, {12'b0, 3'b010, 1'b0}, 4);
    line_a = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("mid_busy_pre", busy_a, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_count", cnt_a, 0);
    chk("mid_rst_valid", valid_a, 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_char(0, 9'h05A, 0, 0);
    wait_valid(0, "post_valid");
    chk("post_data", data_a, 8'h5A);
    chk("post_flags", {perr_a, ferr_a, brk_a}, 0);
    chk("post_count", cnt_a, 1);
    $display("post-reset: data=%0h count=%0d", data_a, cnt_a);
    pop(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
